// File: rtl/jzjpcc_memory_arbiter.sv
// ---------------------------------------------------------------------------
// jzjpcc_memory_arbiter
//
// Shares the data-side port (port B) of the core's SRAM between two masters:
//   master 0 - pipeline memory stage (normally has priority)
//   master 1 - secondary agent (loader / MMIO bridge)
// Grants are combinational in the request cycle. Read data returns one cycle
// later, following the SRAM's synchronous read latency. A starvation counter
// boosts master 1 to priority after MAX_WAIT consecutive denied cycles.
//
// Ports:
//   clock, reset              - clock, asynchronous active-high reset
//   m0_* / m1_*               - request side (req, addr, wen, wdata, byteMask)
//                               and response side (gnt, rvalid, rdata)
//   sram_*                    - SRAM port B address / write data / enables,
//                               plus read data coming back
//   boosted                   - high while master 1 holds priority
// ---------------------------------------------------------------------------
module jzjpcc_memory_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_wen,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_byteMask,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_wen,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_byteMask,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,

    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [31:0]           sram_writeData,
    output logic                  sram_writeEnable,
    output logic [3:0]            sram_byteWriteMask,
    input  logic [31:0]           sram_readData,

    output logic                  boosted
);

    typedef enum logic {
        NORMAL = 1'b0,
        BOOST  = 1'b1
    } state_t;

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       m0_rvalid_q, m0_rvalid_d;
    logic       m1_rvalid_q, m1_rvalid_d;

    // Grants depend only on current requests and the priority state, never on
    // sram_readData, so there is no combinational loop through the SRAM.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (state_q == BOOST) begin
            m1_gnt = m1_req;
            m0_gnt = m0_req & ~m1_req;
        end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req & ~m0_req;
        end
    end

    // SRAM drive: master 0's address is the idle default so the SRAM sees a
    // stable, pipeline-driven address when nothing is granted.
    always_comb begin
        sram_address       = m0_addr;
        sram_writeData     = m0_wdata;
        sram_writeEnable   = 1'b0;
        sram_byteWriteMask = 4'b0000;
        if (m1_gnt) begin
            sram_address       = m1_addr;
            sram_writeData     = m1_wdata;
            sram_writeEnable   = m1_wen;
            sram_byteWriteMask = m1_wen ? m1_byteMask : 4'b0000;
        end else if (m0_gnt) begin
            sram_writeEnable   = m0_wen;
            sram_byteWriteMask = m0_wen ? m0_byteMask : 4'b0000;
        end
    end

    // Next-state: starvation counter, priority FSM and read-return tracking.
    always_comb begin
        wait_cnt_d  = 4'd0;
        state_d     = state_q;
        m0_rvalid_d = m0_gnt & ~m0_wen;
        m1_rvalid_d = m1_gnt & ~m1_wen;

        // Count only cycles in which master 1 is actively denied.
        if (m1_req && !m1_gnt) begin
            wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
        end

        case (state_q)
            NORMAL: begin
                if (wait_cnt_d >= MAX_WAIT_L) begin
                    state_d = BOOST;
                end
            end
            BOOST: begin
                // Boost lasts until master 1 is served or gives up.
                if (m1_gnt || !m1_req) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= NORMAL;
            wait_cnt_q  <= 4'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    // Both masters see the shared read bus; rvalid qualifies whose data it is.
    assign m0_rdata  = sram_readData;
    assign m1_rdata  = sram_readData;
    assign boosted   = (state_q == BOOST);

endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
module tb_jzjpcc_memory_arbiter;

    localparam int AW = 30;
    localparam int MW = 4;

    logic          clock;
    logic          reset;
    logic          m0_req, m0_wen, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata, m0_rdata;
    logic [3:0]    m0_byteMask;
    logic          m1_req, m1_wen, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata, m1_rdata;
    logic [3:0]    m1_byteMask;
    logic [AW-1:0] sram_address;
    logic [31:0]   sram_writeData, sram_readData;
    logic          sram_writeEnable;
    logic [3:0]    sram_byteWriteMask;
    logic          boosted;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    jzjpcc_memory_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_byteMask(m0_byteMask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_byteMask(m1_byteMask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_address(sram_address), .sram_writeData(sram_writeData),
        .sram_writeEnable(sram_writeEnable), .sram_byteWriteMask(sram_byteWriteMask),
        .sram_readData(sram_readData), .boosted(boosted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM port B model: byte-masked write, registered read (read-old-data).
    logic [31:0] mem [0:255];
    logic [7:0]  sram_idx;
    assign sram_idx = sram_address[7:0];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[16] <= 32'hDEAD_BEEF;
            mem[32] <= 32'hAABB_CCDD;
            sram_readData <= 32'h0;
        end else begin
            if (sram_writeEnable) begin
                for (int b = 0; b < 4; b++)
                    if (sram_byteWriteMask[b]) mem[sram_idx][8*b +: 8] <= sram_writeData[8*b +: 8];
            end
            sram_readData <= mem[sram_idx];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_wen = 0; m0_addr = '0; m0_wdata = '0; m0_byteMask = '0;
        m1_req = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0; m1_byteMask = '0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b want 00", m0_rvalid, m1_rvalid); end
        checks++; if (boosted !== 1'b0) begin errors++; $display("FAIL reset_boosted got %b want 0", boosted); end
        checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || sram_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_idle got gnt %b%b we %b want 000", m0_gnt, m1_gnt, sram_writeEnable); end
        checks++; if (dut.wait_cnt_q !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.wait_cnt_q); end
        // Grants follow inputs even while reset is held.
        m1_req = 1;
        #1;
        checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_comb_gnt got %b%b want 01", m0_gnt, m1_gnt); end
        m1_req = 0;
        tick();
        reset = 0;
        $display("test_reset done");
    endtask

    task automatic test_m0_read();
        m0_req = 1; m0_wen = 0; m0_addr = 30'h10; m0_byteMask = 4'hF;
        @(negedge clock);
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL m0_read_gnt got %b%b want 10", m0_gnt, m1_gnt); end
        checks++; if (sram_address !== 30'h10 || sram_writeEnable !== 1'b0 || sram_byteWriteMask !== 4'b0) begin errors++; $display("FAIL m0_read_drive got a=%0h we=%b m=%b want a=10 we=0 m=0", sram_address, sram_writeEnable, sram_byteWriteMask); end
        sb.push_back('{id: 1'b0, data: 32'hDEAD_BEEF});
        tick();
        idle_all();
        @(negedge clock);
        checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL m0_read_rvalid got %b%b want 10", m0_rvalid, m1_rvalid); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL m0_read_sb got empty want entry"); end
        else begin
            e = sb.pop_front();
            if (e.id !== 1'b0 || m0_rdata !== e.data) begin errors++; $display("FAIL m0_read_data got %h want %h", m0_rdata, e.data); end
        end
        tick();
        @(negedge clock);
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL m0_read_pulse got %b want 0", m0_rvalid); end
        tick();
        $display("test_m0_read done");
    endtask

    task automatic test_m1_write();
        m1_req = 1; m1_wen = 1; m1_addr = 30'h20; m1_wdata = 32'h1122_3344; m1_byteMask = 4'b0101;
        @(negedge clock);
        checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++; $display("FAIL m1_write_gnt got %b%b want 01", m0_gnt, m1_gnt); end
        checks++; if (sram_writeEnable !== 1'b1 || sram_byteWriteMask !== 4'b0101) begin errors++; $display("FAIL m1_write_en got we=%b m=%b want we=1 m=0101", sram_writeEnable, sram_byteWriteMask); end
        checks++; if (sram_address !== 30'h20 || sram_writeData !== 32'h1122_3344) begin errors++; $display("FAIL m1_write_bus got a=%0h d=%h want a=20 d=11223344", sram_address, sram_writeData); end
        tick();
        m1_wen = 0;
        @(negedge clock);
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL m1_write_no_rvalid got %b want 0", m1_rvalid); end
        checks++; if (m1_gnt !== 1'b1 || sram_writeEnable !== 1'b0 || sram_byteWriteMask !== 4'b0) begin errors++; $display("FAIL m1_read_drive got g=%b we=%b m=%b want 1 0 0000", m1_gnt, sram_writeEnable, sram_byteWriteMask); end
        sb.push_back('{id: 1'b1, data: 32'hAA22_CC44});
        tick();
        idle_all();
        @(negedge clock);
        checks++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL m1_read_rvalid got %b%b want 01", m0_rvalid, m1_rvalid); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL m1_read_sb got empty want entry"); end
        else begin
            e = sb.pop_front();
            if (e.id !== 1'b1 || m1_rdata !== e.data) begin errors++; $display("FAIL m1_read_data got %h want %h", m1_rdata, e.data); end
        end
        tick();
        $display("test_m1_write done");
    endtask

    task automatic test_back_to_back();
        m0_req = 1; m0_wen = 0; m0_addr = 30'h1;
        @(negedge clock);
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL b2b_m0_gnt got %b want 1", m0_gnt); end
        sb.push_back('{id: 1'b0, data: 32'hA500_0001});
        tick();
        m0_req = 0; m1_req = 1; m1_wen = 0; m1_addr = 30'h2;
        @(negedge clock);
        checks++; if (m1_gnt !== 1'b1 || sram_address !== 30'h2) begin errors++; $display("FAIL b2b_m1_gnt got g=%b a=%0h want 1 2", m1_gnt, sram_address); end
        checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid0 got %b%b want 10", m0_rvalid, m1_rvalid); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_sb0 got empty want entry"); end
        else begin
            e = sb.pop_front();
            if (e.id !== 1'b0 || m0_rdata !== e.data) begin errors++; $display("FAIL b2b_data0 got %h want %h", m0_rdata, e.data); end
        end
        sb.push_back('{id: 1'b1, data: 32'hA500_0002});
        tick();
        idle_all();
        @(negedge clock);
        checks++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid1 got %b%b want 01", m0_rvalid, m1_rvalid); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_sb1 got empty want entry"); end
        else begin
            e = sb.pop_front();
            if (e.id !== 1'b1 || m1_rdata !== e.data) begin errors++; $display("FAIL b2b_data1 got %h want %h", m1_rdata, e.data); end
        end
        tick();
        @(negedge clock);
        checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_quiet got %b%b want 00", m0_rvalid, m1_rvalid); end
        tick();
        $display("test_back_to_back done");
    endtask

    // Masked-off writes keep both masters busy without touching memory or
    // producing read returns.
    task automatic test_contention();
        logic exp_m1;
        m0_req = 1; m0_wen = 1; m0_addr = 30'h5; m0_byteMask = 4'b0000;
        m1_req = 1; m1_wen = 1; m1_addr = 30'h6; m1_byteMask = 4'b0000;
        for (int k = 0; k < 2 * (MW + 1); k++) begin
            exp_m1 = ((k % (MW + 1)) == MW);
            @(negedge clock);
            checks++;
            if (m1_gnt !== exp_m1 || m0_gnt !== !exp_m1 || boosted !== exp_m1) begin
                errors++; $display("FAIL contention_c%0d got g0=%b g1=%b b=%b want g0=%b g1=%b b=%b", k, m0_gnt, m1_gnt, boosted, !exp_m1, exp_m1, exp_m1);
            end
            checks++;
            if (sram_address !== (exp_m1 ? 30'h6 : 30'h5)) begin
                errors++; $display("FAIL contention_addr_c%0d got %0h want %0h", k, sram_address, exp_m1 ? 30'h6 : 30'h5);
            end
            tick();
        end
        idle_all();
        @(negedge clock);
        checks++; if (boosted !== 1'b0) begin errors++; $display("FAIL contention_exit got %b want 0", boosted); end
        tick();
        $display("test_contention done");
    endtask

    task automatic test_m1_abandon();
        logic exp_m1;
        m0_req = 1; m0_wen = 1; m0_addr = 30'h5; m0_byteMask = 4'b0000;
        m1_req = 1; m1_wen = 1; m1_addr = 30'h6; m1_byteMask = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (m1_gnt !== 1'b0 || boosted !== 1'b0) begin errors++; $display("FAIL abandon_wait_c%0d got g1=%b b=%b want 0 0", k, m1_gnt, boosted); end
            tick();
        end
        m1_req = 0;
        @(negedge clock);
        checks++; if (boosted !== 1'b0 || m0_gnt !== 1'b1) begin errors++; $display("FAIL abandon_drop got b=%b g0=%b want 0 1", boosted, m0_gnt); end
        tick();
        m1_req = 1;
        for (int k = 0; k <= MW; k++) begin
            exp_m1 = (k == MW);
            @(negedge clock);
            if (k == 0) begin
                checks++; if (dut.wait_cnt_q !== 4'd0) begin errors++; $display("FAIL abandon_cnt_clear got %0d want 0", dut.wait_cnt_q); end
            end
            checks++; if (m1_gnt !== exp_m1 || boosted !== exp_m1) begin errors++; $display("FAIL abandon_retry_c%0d got g1=%b b=%b want %b %b", k, m1_gnt, boosted, exp_m1, exp_m1); end
            tick();
        end
        idle_all();
        tick();
        $display("test_m1_abandon done");
    endtask

    task automatic test_reset_mid();
        m0_req = 1; m0_wen = 0; m0_addr = 30'h10;
        m1_req = 1; m1_wen = 1; m1_addr = 30'h6; m1_byteMask = 4'b0000;
        @(negedge clock);
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL rmid_gnt got %b%b want 10", m0_gnt, m1_gnt); end
        tick();
        idle_all();
        checks++; if (m0_rvalid !== 1'b1 || dut.wait_cnt_q !== 4'd1) begin errors++; $display("FAIL rmid_pre got rv=%b cnt=%0d want 1 1", m0_rvalid, dut.wait_cnt_q); end
        #1 reset = 1;
        #1;
        checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid got %b%b want 00", m0_rvalid, m1_rvalid); end
        checks++; if (boosted !== 1'b0 || dut.wait_cnt_q !== 4'd0) begin errors++; $display("FAIL rmid_state got b=%b cnt=%0d want 0 0", boosted, dut.wait_cnt_q); end
        tick();
        reset = 0;
        @(negedge clock);
        checks++; if (m0_rvalid !== 1'b0 || boosted !== 1'b0 || dut.wait_cnt_q !== 4'd0) begin errors++; $display("FAIL rmid_after got rv=%b b=%b cnt=%0d want 0 0 0", m0_rvalid, boosted, dut.wait_cnt_q); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
        tick();
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1;
        idle_all();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_back_to_back();
        test_contention();
        test_m1_abandon();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jzjpcc_memory_arbiter.md
Name: jzjpcc_memory_arbiter

Overview:
Shares the single data-side port (port B) of the core's inferred SRAM between two requesters: master 0, the pipeline memory stage, and master 1, a secondary agent such as a program loader or MMIO bridge. Grants are issued combinationally in the request cycle so that the pipeline sees zero added latency when uncontended. Read data returns with the SRAM's one-cycle synchronous latency. A starvation timer guarantees that master 1 makes forward progress under continuous master-0 traffic.

Parameters:
ADDR_WIDTH, 30, word-address width (byte address bits 31:2).
MAX_WAIT, 4, number of consecutive denied cycles for master 1 before it is boosted; legal range 1..15.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
m0_req  input  1  master 0 access request.
m0_addr  input  ADDR_WIDTH  master 0 word address.
m0_wen  input  1  master 0 write (1) or read (0).
m0_wdata  input  32  master 0 write data.
m0_byteMask  input  4  master 0 byte-write mask; bit i enables byte i.
m0_gnt  output  1  master 0 access accepted this cycle.
m0_rvalid  output  1  master 0 read data valid.
m0_rdata  output  32  master 0 read data.
m1_req, m1_addr, m1_wen, m1_wdata, m1_byteMask  input  (same widths)  master 1 request signals, with the same meanings as master 0.
m1_gnt, m1_rvalid, m1_rdata  output  (same widths)  master 1 responses, with the same meanings as master 0.
sram_address  output  ADDR_WIDTH  SRAM port B address.
sram_writeData  output  32  SRAM port B write data.
sram_writeEnable  output  1  SRAM port B write enable.
sram_byteWriteMask  output  4  SRAM port B byte mask.
sram_readData  input  32  SRAM port B read data; valid one cycle after the address is presented.
boosted  output  1  high while the FSM is in state BOOST (debug/perf).

Behaviour:
- Reset values:
  - FSM state = NORMAL.
  - wait counter = 0.
  - m0_rvalid = m1_rvalid = 0.
  - boosted = 0.
  - gnt outputs depend only on the current inputs, so they are 0 whenever req is 0.
- FSM has two states, NORMAL and BOOST.
- Grant logic is combinational:
  - NORMAL: master 0 wins whenever m0_req is high; master 1 is granted only if m1_req is high and m0_req is low.
  - BOOST: master 1 wins whenever m1_req is high; master 0 is granted only if m1_req is low.
  - At most one gnt is high per cycle.
- Request rule: a master holds req, addr, wen, wdata and byteMask stable until it sees gnt. The arbiter does not latch requests. Dropping req before gnt is legal and abandons the request.
- SRAM drive:
  - The selected master's fields are muxed onto the sram_* outputs.
  - With no grant: sram_address = m0_addr, sram_writeEnable = 0, sram_byteWriteMask = 0.
  - sram_writeEnable = granted master's wen.
  - sram_byteWriteMask = granted master's byteMask when wen = 1, else 0.
- Read return:
  - Registered: mX_rvalid is 1 in the cycle after mX_gnt with mX_wen = 0; otherwise 0.
  - mX_rdata = sram_readData; the value is meaningful only when rvalid = 1.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating masters each return correctly in their own following cycle.
- Wait counter (4 bits):
  - Increments each cycle with m1_req = 1 and m1_gnt = 0, saturating at 15.
  - Clears when m1_req = 0 or m1_gnt = 1.
- FSM transitions:
  - NORMAL -> BOOST when the counter's next value reaches MAX_WAIT.
  - BOOST -> NORMAL on the edge after any m1_gnt, or when m1_req drops.
- Simultaneous events:
  - In BOOST with both requests high, master 1 wins.
  - In the same cycle as that grant, the counter clears, and master 0 is denied; master 0 simply retries.
- Reset mid-operation: asserting reset drops a pending rvalid (that read is lost), forces NORMAL and clears the counter. Requesters must reissue.
- No combinational path exists from sram_readData to any gnt.

Test Plan:
1. Only m0 reads addr 0x10 (SRAM preloaded 0xDEADBEEF) -> m0_gnt = 1 in the same cycle; next cycle m0_rvalid = 1 and m0_rdata = 0xDEADBEEF; m1_rvalid stays 0.
2. m1 writes addr 0x20, wdata 0x11223344, byteMask 4'b0101 while m0 idle -> sram_writeEnable = 1, sram_byteWriteMask = 4'b0101 in the grant cycle; a subsequent m1 read of 0x20 returns bytes 0 and 2 updated only.
3. Both request continuously with MAX_WAIT = 4 -> m0 granted for 4 cycles, boosted = 1, m1 granted on cycle 5, then NORMAL; the pattern repeats every 5 cycles.
4. Alternating reads: m0 reads 0x1, m1 reads 0x2 in the next cycle -> m0_rvalid and m1_rvalid each pulse exactly once, in consecutive cycles, with the correct data.
5. m1 waits 3 cycles then drops req -> counter clears, no BOOST; re-request waits a full MAX_WAIT again.
6. Assert reset the cycle after an m0 read grant -> m0_rvalid = 0 immediately, boosted = 0, and the counter = 0 after release.
